// File: rtl/qspi_pkg.sv
`default_nettype none
// ============================================================
// Package : qspi_pkg
// Desc    : Shared widths and helpers for the QSPI read path.
// Rev     : 1.0
// ============================================================
package qspi_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_sync_fifo.sv
`default_nettype none
// ============================================================
// Module : qspi_sync_fifo
// Desc   : First-word-fall-through synchronous FIFO with flush.
// Rev    : 1.0
// ============================================================
module qspi_sync_fifo
  import qspi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                      sclk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_rdata,
  output logic [level_w(DEPTH)-1:0] o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push & ~o_full & ~i_flush;
  assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;
  // Head is masked while empty so stale storage never leaks out.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge sclk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/qspi_rd_buffer.sv
`default_nettype none
// ============================================================
// Module : qspi_rd_buffer
// Desc   : Packs flash bytes into LE words, buffers them, tracks burst.
// Rev    : 1.0
// ============================================================
module qspi_rd_buffer
  import qspi_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int BURST_W = 8
) (
  input  logic                      sclk,
  input  logic                      rst_n,
  input  logic                      flush_in,
  input  logic [BURST_W-1:0]        burst_len_in,
  input  logic                      wr_rd_buffr_en_in,
  input  logic [BYTE_W-1:0]         wr_data_in,
  output logic                      rd_buffr_full_out,
  output logic                      burst_comp_out,
  output logic                      rd_valid_out,
  input  logic                      rd_ready_in,
  output logic [WORD_W-1:0]         rd_data_out,
  output logic [level_w(DEPTH)-1:0] level_out,
  output logic                      overflow_out
);

  logic [1:0]         r_lane;
  logic [23:0]        r_pack;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] r_burst_len;
  logic               r_overflow;
  logic               r_burst_comp;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_push;
  logic [BURST_W-1:0] w_cnt_nxt;

  assign w_accept  = wr_rd_buffr_en_in & ~w_full & ~flush_in;
  assign w_push    = w_accept & (r_lane == 2'd3);
  assign w_cnt_nxt = (r_burst_cnt == '1) ? r_burst_cnt : r_burst_cnt + BURST_W'(1);

  qspi_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .i_flush (flush_in),
    .i_push  (w_push),
    .i_wdata ({wr_data_in, r_pack}),
    .i_pop   (rd_ready_in),
    .o_rdata (rd_data_out),
    .o_count (level_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rd_buffr_full_out = w_full;
  assign rd_valid_out      = ~w_empty;
  assign overflow_out      = r_overflow;
  assign burst_comp_out    = r_burst_comp;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane       <= 2'd0;
      r_pack       <= '0;
      r_burst_cnt  <= '0;
      r_burst_len  <= '0;
      r_overflow   <= 1'b0;
      r_burst_comp <= 1'b0;
    end else if (flush_in) begin
      r_lane       <= 2'd0;
      r_pack       <= '0;
      r_burst_cnt  <= '0;
      r_burst_len  <= burst_len_in;
      r_overflow   <= 1'b0;
      r_burst_comp <= 1'b0;
    end else begin
      if (wr_rd_buffr_en_in && w_full) r_overflow <= 1'b1;
      if (w_accept) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_pack[7:0]   <= wr_data_in;
          2'd1:    r_pack[15:8]  <= wr_data_in;
          2'd2:    r_pack[23:16] <= wr_data_in;
          default: r_pack        <= r_pack;
        endcase
      end
      // Completion is sticky so saturating past the length cannot clear it.
      if (w_push) begin
        r_burst_cnt <= w_cnt_nxt;
        if ((r_burst_len != '0) && (w_cnt_nxt == r_burst_len)) r_burst_comp <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_rd_buffer.sv
`default_nettype none
// ============================================================
// Module : tb_qspi_rd_buffer
// Desc   : Scoreboard bench for the QSPI read buffer.
// Rev    : 1.0
// ============================================================
module tb_qspi_rd_buffer;

  localparam int DEPTH   = 8;
  localparam int BURST_W = 8;

  logic         sclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_in = 1'b0;
  logic [7:0]   burst_len_in = '0;
  logic         wr_rd_buffr_en_in = 1'b0;
  logic [7:0]   wr_data_in = '0;
  logic         rd_buffr_full_out;
  logic         burst_comp_out;
  logic         rd_valid_out;
  logic         rd_ready_in = 1'b0;
  logic [31:0]  rd_data_out;
  logic [3:0]   level_out;
  logic         overflow_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  m_lane;
  logic [23:0] m_pack;
  int          m_level;

  qspi_rd_buffer #(.DEPTH(DEPTH), .BURST_W(BURST_W)) dut (
    .sclk              (sclk),
    .rst_n             (rst_n),
    .flush_in          (flush_in),
    .burst_len_in      (burst_len_in),
    .wr_rd_buffr_en_in (wr_rd_buffr_en_in),
    .wr_data_in        (wr_data_in),
    .rd_buffr_full_out (rd_buffr_full_out),
    .burst_comp_out    (burst_comp_out),
    .rd_valid_out      (rd_valid_out),
    .rd_ready_in       (rd_ready_in),
    .rd_data_out       (rd_data_out),
    .level_out         (level_out),
    .overflow_out      (overflow_out)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge sclk);
      if (rst_n && !flush_in && rd_valid_out && rd_ready_in) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got 0x%08h expected nothing", rd_data_out);
        end else begin
          check("sb_pop_data", rd_data_out, exp_q.pop_front());
        end
      end
    end
  end

  function automatic void model_clear();
    exp_q.delete();
    m_lane  = 2'd0;
    m_pack  = '0;
    m_level = 0;
  endfunction

  // One clock of stimulus; the model predicts what the edge will do.
  task automatic drive(input logic wr, input logic [7:0] d, input logic rdy,
                       input logic fl, input logic [7:0] len);
    int pushed;
    int popped;
    wr_rd_buffr_en_in = wr;
    wr_data_in        = d;
    rd_ready_in       = rdy;
    flush_in          = fl;
    burst_len_in      = len;
    pushed = 0;
    popped = (rdy && m_level > 0) ? 1 : 0;
    if (fl) begin
      model_clear();
      popped = 0;
    end else if (wr && m_level < DEPTH) begin
      case (m_lane)
        2'd0: m_pack[7:0]   = d;
        2'd1: m_pack[15:8]  = d;
        2'd2: m_pack[23:16] = d;
        default: begin
          exp_q.push_back({d, m_pack});
          pushed = 1;
        end
      endcase
      m_lane = m_lane + 2'd1;
    end
    m_level = m_level + pushed - popped;
    @(posedge sclk);
    #1;
    wr_rd_buffr_en_in = 1'b0;
    rd_ready_in       = 1'b0;
    flush_in          = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic pop();
    drive(1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic flush(input logic [7:0] len);
    drive(1'b0, 8'd0, 1'b0, 1'b1, len);
  endtask

  initial begin
    model_clear();
    #2;
    check("rst_valid", 32'(rd_valid_out), 32'd0);
    check("rst_level", 32'(level_out), 32'd0);
    check("rst_data", rd_data_out, 32'd0);
    check("rst_full_ovf_comp", {29'd0, rd_buffr_full_out, overflow_out, burst_comp_out}, 32'd0);
    @(posedge sclk); #1;
    rst_n = 1'b1;

    // Packing and burst completion with length 2
    flush(8'd2);
    wr(8'h11); wr(8'h22); wr(8'h33);
    check("pack_not_yet_valid", 32'(rd_valid_out), 32'd0);
    wr(8'h44);
    check("pack_valid", 32'(rd_valid_out), 32'd1);
    check("pack_data", rd_data_out, 32'h44332211);
    check("pack_level", 32'(level_out), 32'd1);
    check("pack_comp", 32'(burst_comp_out), 32'd0);
    wr(8'h55); wr(8'h66); wr(8'h77); wr(8'h88);
    check("burst_comp_set", 32'(burst_comp_out), 32'd1);
    check("burst_level", 32'(level_out), 32'd2);
    for (int i = 0; i < 4; i++) wr(8'(8'h90 + i));
    check("burst_comp_hold", 32'(burst_comp_out), 32'd1);
    check("burst_extra_stored", 32'(level_out), 32'd3);
    pop();
    check("pop_head_advance", rd_data_out, 32'h88776655);
    flush(8'd0);
    check("flush_comp", 32'(burst_comp_out), 32'd0);
    check("flush_level", 32'(level_out), 32'd0);
    check("flush_valid", 32'(rd_valid_out), 32'd0);

    // Full and overflow with unbounded burst
    for (int i = 0; i < 4 * DEPTH; i++) wr(8'(i * 7 + 3));
    check("full_flag", 32'(rd_buffr_full_out), 32'd1);
    check("full_level", 32'(level_out), 32'(DEPTH));
    check("len0_no_comp", 32'(burst_comp_out), 32'd0);
    check("no_ovf_yet", 32'(overflow_out), 32'd0);
    wr(8'hAA);
    check("ovf_set", 32'(overflow_out), 32'd1);
    check("ovf_level", 32'(level_out), 32'(DEPTH));
    pop();
    check("unfull_after_pop", 32'(rd_buffr_full_out), 32'd0);
    wr(8'hC0); wr(8'hC1); wr(8'hC2); wr(8'hC3);
    check("refill_full", 32'(rd_buffr_full_out), 32'd1);
    for (int i = 0; i < DEPTH; i++) pop();
    check("drain_empty", 32'(rd_valid_out), 32'd0);
    check("ovf_sticky", 32'(overflow_out), 32'd1);
    flush(8'd0);
    check("ovf_cleared", 32'(overflow_out), 32'd0);

    // Simultaneous push and pop at level 3
    for (int i = 0; i < 12; i++) wr(8'(8'h30 + i));
    check("sim_level_pre", 32'(level_out), 32'd3);
    wr(8'hD0); wr(8'hD1); wr(8'hD2);
    drive(1'b1, 8'hD3, 1'b1, 1'b0, 8'd0);
    check("sim_level_hold", 32'(level_out), 32'd3);
    for (int i = 0; i < 3; i++) pop();
    check("sim_drained", 32'(rd_valid_out), 32'd0);

    // Flush mid-word with a same-cycle byte strobe
    wr(8'h01); wr(8'h02);
    drive(1'b1, 8'h03, 1'b0, 1'b1, 8'd0);
    check("midflush_level", 32'(level_out), 32'd0);
    wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    check("midflush_data", rd_data_out, 32'hA3A2A1A0);
    check("midflush_level1", 32'(level_out), 32'd1);
    pop();

    // Asynchronous reset mid-burst
    flush(8'd9);
    for (int i = 0; i < 22; i++) wr(8'(8'h60 + i));
    check("arst_level_pre", 32'(level_out), 32'd5);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("arst_valid", 32'(rd_valid_out), 32'd0);
    check("arst_level", 32'(level_out), 32'd0);
    check("arst_data", rd_data_out, 32'd0);
    check("arst_full_ovf_comp", {29'd0, rd_buffr_full_out, overflow_out, burst_comp_out}, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge sclk); #1;
    wr(8'hE0); wr(8'hE1); wr(8'hE2); wr(8'hE3);
    check("arst_clean_word", rd_data_out, 32'hE3E2E1E0);
    check("arst_clean_level", 32'(level_out), 32'd1);
    pop();
    check("final_empty", 32'(rd_valid_out), 32'd0);

    #20;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qspi_rd_buffer.md
Name: qspi_rd_buffer

Overview:
- Read buffer directly downstream of the QSPI controller FSM; clocked by the flash-side serial clock.
- Accepts sampled bytes from the QSPI data sample register on each controller write strobe and packs them into 32-bit words, little-endian.
- Stores packed words in a first-word-fall-through FIFO that the AHB slave side drains.
- Returns the full and burst-complete status that the controller FSM uses for its WAIT and DATA_SHIFT decisions.

Parameters:
- DEPTH, 8: FIFO depth in 32-bit words; power of two, >= 2.
- BURST_W, 8: width of the burst length and burst word counter.

Ports:
- sclk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_in  input  1  start of a new XIP sequence; clears buffer and latches burst_len_in.
- burst_len_in  input  BURST_W  burst length in words, sampled when flush_in=1; 0 = unbounded.
- wr_rd_buffr_en_in  input  1  controller write strobe; one byte per strobe.
- wr_data_in  input  8  sampled byte from the data sample register.
- rd_buffr_full_out  output  1  FIFO holds DEPTH words.
- burst_comp_out  output  1  programmed number of words pushed.
- rd_valid_out  output  1  FIFO non-empty.
- rd_ready_in  input  1  AHB side pops head word when rd_valid_out=1.
- rd_data_out  output  32  head word; valid while rd_valid_out=1.
- level_out  output  $clog2(DEPTH)+1  current word count.
- overflow_out  output  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, rd_data_out 0. Pointers, count, byte lane, pack register, burst counter and latched length all 0.
- Byte packing:
  - A write is accepted when wr_rd_buffr_en_in=1 and rd_buffr_full_out=0.
  - An accepted byte goes to pack lane `lane` (bits 8*lane+7:8*lane), then lane increments mod 4.
  - On the accept with lane==3, the word {wr_data_in, pack[23:0]} is pushed into the FIFO in the same edge and lane wraps to 0.
  - Latency from 4th byte strobe to rd_valid_out=1 is one sclk.
- Full: rd_buffr_full_out = (count == DEPTH), purely from registered count.
  - Writes while full are dropped entirely: no lane advance, no pack update, overflow_out set to 1.
  - overflow_out stays 1 until flush_in or reset.
- Pop: occurs when rd_valid_out & rd_ready_in. rd_ptr increments mod DEPTH; rd_data_out shows the new head combinationally from storage.
  - rd_ready_in with rd_valid_out=0 is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full is impossible, because writes are dropped when full.
  - Pop making room in the same cycle as a full write does not rescue that write; full is evaluated on the registered count.
- Burst counter:
  - Increments on every word push, saturating at its maximum.
  - burst_comp_out = 1 when latched length != 0 and counter == latched length. Registered, so it asserts the cycle after the final push and holds until flush_in.
  - Pushes after burst complete are still stored; the controller is expected to stop.
  - Latched length 0 gives burst_comp_out = 0 permanently.
- Flush: flush_in=1 at an edge clears count, pointers, lane, pack register, burst counter, overflow_out and burst_comp_out, and latches burst_len_in.
  - Flush has priority over a same-cycle write or pop; both are discarded.
  - A partial word in the pack register is discarded.
- Reset mid-operation: asynchronous clear of everything, identical to reset values; no partial word survives.
- Storage: DEPTH x 32 register array, written only on push; no reset required on array contents.

Decomposition:
- qspi_pkg carries:
  - localparam WORD_W=32 and BYTE_W=8.
  - Function for level width, $clog2(DEPTH)+1.
- One sub-module: qspi_sync_fifo, a generic FWFT synchronous FIFO with push, pop, flush, count, full and empty.
- qspi_rd_buffer contains the byte packer, burst counter, overflow flag and the FIFO instance.

Test Plan:
- Packing: flush with len=2; write bytes 0x11,0x22,0x33,0x44 -> one sclk after the 4th strobe, rd_valid_out=1, rd_data_out=0x44332211, level_out=1, burst_comp_out=0.
- Burst complete: continue 0x55,0x66,0x77,0x88 -> second word 0x88776655 pushed; burst_comp_out=1 the next cycle; flush_in -> burst_comp_out=0, level_out=0.
- Full / overflow (DEPTH=8): len=0, push 32 bytes, no pops -> rd_buffr_full_out=1, level_out=8. Write 0xAA -> dropped, overflow_out=1. Pop once -> full=0; next 4 bytes packed from lane 0.
- Simultaneous push and pop at level_out=3: 4th byte strobe in the same cycle as a pop -> level_out stays 3, data order preserved (FIFO sequence check against a model).
- Flush mid-word: write 0x01,0x02, then flush_in with a byte strobe in the same cycle -> lane=0, level_out=0. Next 4 bytes 0xA0..0xA3 give 0xA3A2A1A0.
- Async reset mid-burst: rst_n low between sclk edges with level_out=5 and lane=2 -> all outputs 0 immediately; after release, first 4 bytes produce a clean word.
